// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the 3x3 matrix-multiplier sequencer: the matrix
// geometry, the operand/result widths, the sequencer state encoding and the
// row-major packing index used for every flattened matrix bus.
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int unsigned N            = 3;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned RES_W        = 16;
  localparam int unsigned NUM_OPERANDS = 2 * N * N;
  localparam int unsigned NUM_RESULTS  = N * N;

  typedef enum logic [1:0] {
    StLoad,
    StFire,
    StWait,
    StDrain
  } state_e;

  // Row-major position of element (i,j) in a flattened N x N matrix.
  function automatic int unsigned idx(input int unsigned i, input int unsigned j);
    return i * N + j;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequencer for the 3x3 8-bit matrix multiplier. Loads 18 operand bytes
// (A row-major, then B row-major) from a valid/ready byte stream, pulses the
// multiplier enable once, captures the 9 results MUL_LAT cycles later and
// streams them out row-major over a valid/ready word interface.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_abort             synchronous abort: drop the current job, back to LOAD
//   i_in_valid/o_in_ready/i_in_data   operand byte stream
//   o_a_flat, o_b_flat  operands to multiplier, element (i,j) at idx(i,j)*DATA_W
//   o_mul_en            one-cycle multiplier enable per job
//   i_r_flat            multiplier results, element (i,j) at idx(i,j)*RES_W
//   o_out_valid/i_out_ready/o_out_data/o_out_idx/o_out_last  result word stream
//   o_busy              low only in LOAD with no operand bytes taken
//   o_job_cnt           completed jobs, wraps at 16 bits
// -----------------------------------------------------------------------------
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_abort,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DATA_W-1:0]         i_in_data,
  output logic [N*N*DATA_W-1:0]     o_a_flat,
  output logic [N*N*DATA_W-1:0]     o_b_flat,
  output logic                      o_mul_en,
  input  logic [N*N*RES_W-1:0]      i_r_flat,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [RES_W-1:0]          o_out_data,
  output logic [3:0]                o_out_idx,
  output logic                      o_out_last,
  output logic                      o_busy,
  output logic [15:0]               o_job_cnt
);

  if (N != 3) begin : g_bad_n
    $error("matmul_seq_ctrl supports only N == 3");
  end
  if (MUL_LAT < 1) begin : g_bad_lat
    $error("matmul_seq_ctrl requires MUL_LAT >= 1");
  end

  localparam int unsigned     LatW    = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [4:0]      LastLd  = 5'(NUM_OPERANDS - 1);
  localparam logic [3:0]      LastRd  = 4'(NUM_RESULTS - 1);
  localparam logic [LatW-1:0] LatDone = LatW'(MUL_LAT);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [4:0]              r_ld_cnt;
  logic [LatW-1:0]         r_lat_cnt;
  logic [3:0]              r_rd_idx;
  logic [15:0]             r_job_cnt;
  logic [N*N*DATA_W-1:0]   r_a_flat;
  logic [N*N*DATA_W-1:0]   r_b_flat;
  logic [RES_W-1:0]        r_res [NUM_RESULTS];

  logic w_in_hs;
  logic w_out_hs;
  logic w_lat_done;

  assign w_in_hs    = i_in_valid && (r_state == StLoad);
  assign w_out_hs   = i_out_ready && (r_state == StDrain);
  assign w_lat_done = (r_lat_cnt == LatDone);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StLoad:  if (w_in_hs && (r_ld_cnt == LastLd)) w_state_nxt = StFire;
      StFire:  w_state_nxt = StWait;
      StWait:  if (w_lat_done) w_state_nxt = StDrain;
      StDrain: if (w_out_hs && (r_rd_idx == LastRd)) w_state_nxt = StLoad;
      default: w_state_nxt = StLoad;
    endcase
    // Abort overrides everything, including a handshake in the same cycle.
    if (i_abort) w_state_nxt = StLoad;
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_cnt  <= '0;
      r_lat_cnt <= '0;
      r_rd_idx  <= '0;
      r_job_cnt <= '0;
    end else if (i_abort) begin
      r_ld_cnt  <= '0;
      r_lat_cnt <= '0;
      r_rd_idx  <= '0;
    end else begin
      case (r_state)
        StLoad: begin
          if (w_in_hs) r_ld_cnt <= (r_ld_cnt == LastLd) ? '0 : r_ld_cnt + 5'd1;
        end
        // The FIRE edge counts as the first latency cycle.
        StFire: r_lat_cnt <= LatW'(1);
        StWait: begin
          if (w_lat_done) r_lat_cnt <= '0;
          else            r_lat_cnt <= r_lat_cnt + LatW'(1);
        end
        StDrain: begin
          if (w_out_hs) begin
            if (r_rd_idx == LastRd) begin
              r_rd_idx  <= '0;
              r_job_cnt <= r_job_cnt + 16'd1;
            end else begin
              r_rd_idx <= r_rd_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand registers: slot ld_cnt 0..8 -> A, 9..17 -> B. Kept on abort.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_flat <= '0;
      r_b_flat <= '0;
    end else if (w_in_hs && !i_abort) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (r_ld_cnt == 5'(idx(i, j))) begin
            r_a_flat[idx(i, j)*DATA_W +: DATA_W] <= i_in_data;
          end
          if (r_ld_cnt == 5'(idx(i, j) + NUM_RESULTS)) begin
            r_b_flat[idx(i, j)*DATA_W +: DATA_W] <= i_in_data;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result buffer: captured once per job so the multiplier output may change
  // freely while the words drain under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_RESULTS; k++) r_res[k] <= '0;
    end else if ((r_state == StWait) && w_lat_done && !i_abort) begin
      for (int unsigned k = 0; k < NUM_RESULTS; k++) begin
        r_res[k] <= i_r_flat[k*RES_W +: RES_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_in_ready  = (r_state == StLoad);
  assign o_mul_en    = (r_state == StFire);
  assign o_out_valid = (r_state == StDrain);
  assign o_out_data  = r_res[r_rd_idx];
  assign o_out_idx   = r_rd_idx;
  assign o_out_last  = (r_state == StDrain) && (r_rd_idx == LastRd);
  assign o_busy      = !((r_state == StLoad) && (r_ld_cnt == 5'd0));
  assign o_job_cnt   = r_job_cnt;
  assign o_a_flat    = r_a_flat;
  assign o_b_flat    = r_b_flat;

endmodule
